// File: rtl/te_block_sequencer.sv
// te_block_sequencer: serialises a connector block group into one block per cycle for a single-port encoder.
// Optional TE_SEQ_FLUSH_EN adds flush_i to abandon the in-flight group.
module te_block_sequencer #(
   parameter int N           = 2,
   parameter int XLEN        = 64,
   parameter int ITYPE_LEN   = 3,
   parameter int IRETIRE_LEN = 32,
   parameter int PRIV_LEN    = 2,
   parameter int DROP_CNT_W  = 8
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
`ifdef TE_SEQ_FLUSH_EN
   input  logic                                flush_i,
`endif
   input  logic [N-1:0]                        blk_valid_i,
   input  logic [N-1:0][IRETIRE_LEN-1:0]       blk_iretire_i,
   input  logic [N-1:0]                        blk_ilastsize_i,
   input  logic [N-1:0][ITYPE_LEN-1:0]         blk_itype_i,
   input  logic [N-1:0][XLEN-1:0]              blk_iaddr_i,
   input  logic [XLEN-1:0]                     cause_i,
   input  logic [XLEN-1:0]                     tval_i,
   input  logic [PRIV_LEN-1:0]                 priv_i,
   output logic                                grp_ready_o,
   output logic                                valid_o,
   input  logic                                ready_i,
   output logic [IRETIRE_LEN-1:0]              iretire_o,
   output logic                                ilastsize_o,
   output logic [ITYPE_LEN-1:0]                itype_o,
   output logic [XLEN-1:0]                     iaddr_o,
   output logic [XLEN-1:0]                     cause_o,
   output logic [XLEN-1:0]                     tval_o,
   output logic [PRIV_LEN-1:0]                 priv_o,
   output logic                                last_o,
   output logic                                drop_o,
   output logic [DROP_CNT_W-1:0]               drop_cnt_o
);
   localparam int SW = N > 1 ? $clog2(N) : 1;
   typedef enum logic {IDLE, EMIT} state_t;
   state_t                          state_q;
   logic [N-1:0]                    rem_q;
   logic [N-1:0][IRETIRE_LEN-1:0]   iretire_q;
   logic [N-1:0]                    ilastsize_q;
   logic [N-1:0][ITYPE_LEN-1:0]     itype_q;
   logic [N-1:0][XLEN-1:0]          iaddr_q;
   logic [XLEN-1:0]                 cause_q;
   logic [XLEN-1:0]                 tval_q;
   logic [PRIV_LEN-1:0]             priv_q;
   logic [SW-1:0]                   sel;
   logic [N-1:0]                    lsb;
   logic                            present, capture, hs, flush, is_exc;
`ifdef TE_SEQ_FLUSH_EN
   assign flush = flush_i;
`else
   assign flush = 1'b0;
`endif
   always_comb begin
      sel = '0;
      for (int i = N - 1; i >= 0; i--)
         if (rem_q[i]) sel = i[SW-1:0];
   end
   assign lsb         = rem_q & (~rem_q + N'(1));
   assign valid_o     = state_q == EMIT;
   assign last_o      = valid_o && ((rem_q & ~lsb) == '0);
   assign hs          = valid_o && ready_i;
   assign grp_ready_o = !valid_o || (ready_i && last_o);
   assign present     = |blk_valid_i;
   assign capture     = present && grp_ready_o && !flush;
   assign drop_o      = present && !grp_ready_o && !flush;
   assign iretire_o   = valid_o ? iretire_q[sel] : '0;
   assign ilastsize_o = valid_o ? ilastsize_q[sel] : 1'b0;
   assign itype_o     = valid_o ? itype_q[sel] : '0;
   assign iaddr_o     = valid_o ? iaddr_q[sel] : '0;
   assign priv_o      = valid_o ? priv_q : '0;
   // cause/tval only travel with exception and interrupt blocks
   assign is_exc      = itype_o == ITYPE_LEN'(1) || itype_o == ITYPE_LEN'(2);
   assign cause_o     = is_exc ? cause_q : '0;
   assign tval_o      = is_exc ? tval_q : '0;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         rem_q       <= '0;
         iretire_q   <= '0;
         ilastsize_q <= '0;
         itype_q     <= '0;
         iaddr_q     <= '0;
         cause_q     <= '0;
         tval_q      <= '0;
         priv_q      <= '0;
         drop_cnt_o  <= '0;
      end else if (flush) begin
         state_q <= IDLE;
         rem_q   <= '0;
      end else begin
         if (drop_o && drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + DROP_CNT_W'(1);
         if (capture) begin
            state_q     <= EMIT;
            rem_q       <= blk_valid_i;
            iretire_q   <= blk_iretire_i;
            ilastsize_q <= blk_ilastsize_i;
            itype_q     <= blk_itype_i;
            iaddr_q     <= blk_iaddr_i;
            cause_q     <= cause_i;
            tval_q      <= tval_i;
            priv_q      <= priv_i;
         end else if (hs) begin
            rem_q <= rem_q & ~lsb;
            if (last_o) state_q <= IDLE;
         end
      end
   end
endmodule

// File: tb/tb_te_block_sequencer.sv
// tb_te_block_sequencer: directed self-checking bench for te_block_sequencer (default build, N=2).
module tb_te_block_sequencer;
   logic             clk_i = 1'b0;
   logic             rst_i;
   logic [1:0]       blk_valid_i;
   logic [1:0][31:0] blk_iretire_i;
   logic [1:0]       blk_ilastsize_i;
   logic [1:0][2:0]  blk_itype_i;
   logic [1:0][63:0] blk_iaddr_i;
   logic [63:0]      cause_i, tval_i;
   logic [1:0]       priv_i;
   logic             grp_ready_o, valid_o, ready_i;
   logic [31:0]      iretire_o;
   logic             ilastsize_o;
   logic [2:0]       itype_o;
   logic [63:0]      iaddr_o, cause_o, tval_o;
   logic [1:0]       priv_o;
   logic             last_o, drop_o;
   logic [7:0]       drop_cnt_o;
   int               errors = 0;
   int               checks = 0;

   te_block_sequencer dut (
      .clk_i(clk_i), .rst_i(rst_i), .blk_valid_i(blk_valid_i), .blk_iretire_i(blk_iretire_i),
      .blk_ilastsize_i(blk_ilastsize_i), .blk_itype_i(blk_itype_i), .blk_iaddr_i(blk_iaddr_i),
      .cause_i(cause_i), .tval_i(tval_i), .priv_i(priv_i), .grp_ready_o(grp_ready_o),
      .valid_o(valid_o), .ready_i(ready_i), .iretire_o(iretire_o), .ilastsize_o(ilastsize_o),
      .itype_o(itype_o), .iaddr_o(iaddr_o), .cause_o(cause_o), .tval_o(tval_o), .priv_o(priv_o),
      .last_o(last_o), .drop_o(drop_o), .drop_cnt_o(drop_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic grp(input logic [1:0] v, input logic [2:0] t1, input logic [2:0] t0,
                      input logic [63:0] a1, input logic [63:0] a0,
                      input logic [63:0] c, input logic [63:0] tv);
      blk_valid_i = v;
      blk_itype_i = {t1, t0};
      blk_iaddr_i = {a1, a0};
      cause_i     = c;
      tval_i      = tv;
   endtask

   task automatic clr();
      grp(2'b00, 3'd0, 3'd0, 64'h0, 64'h0, 64'h0, 64'h0);
      blk_iretire_i   = '0;
      blk_ilastsize_i = '0;
      priv_i          = '0;
   endtask

   initial begin
      rst_i   = 1'b1;
      ready_i = 1'b1;
      clr();
      tick();
      tick();
      rst_i = 1'b0;
      #1;
      chk("rst_valid", 64'(valid_o), 64'd0);
      chk("rst_grp_ready", 64'(grp_ready_o), 64'd1);
      chk("rst_drop_cnt", 64'(drop_cnt_o), 64'd0);
      chk("rst_iaddr", iaddr_o, 64'd0);
      // two-block group, slot 0 first
      grp(2'b11, 3'd0, 3'd6, 64'h80001000, 64'h80000000, 64'h55, 64'h66);
      blk_iretire_i   = {32'd9, 32'd3};
      blk_ilastsize_i = 2'b01;
      priv_i          = 2'd3;
      #1;
      chk("t1_grp_ready", 64'(grp_ready_o), 64'd1);
      chk("t1_no_drop", 64'(drop_o), 64'd0);
      tick();
      clr();
      chk("t1_b0_valid", 64'(valid_o), 64'd1);
      chk("t1_b0_iaddr", iaddr_o, 64'h80000000);
      chk("t1_b0_last", 64'(last_o), 64'd0);
      chk("t1_b0_itype", 64'(itype_o), 64'd6);
      chk("t1_b0_iretire", 64'(iretire_o), 64'd3);
      chk("t1_b0_ilastsize", 64'(ilastsize_o), 64'd1);
      chk("t1_b0_priv", 64'(priv_o), 64'd3);
      chk("t1_b0_cause_gated", cause_o, 64'd0);
      tick();
      chk("t1_b1_iaddr", iaddr_o, 64'h80001000);
      chk("t1_b1_last", 64'(last_o), 64'd1);
      chk("t1_b1_iretire", 64'(iretire_o), 64'd9);
      chk("t1_b1_grp_ready", 64'(grp_ready_o), 64'd1);
      tick();
      chk("t1_idle_valid", 64'(valid_o), 64'd0);
      chk("t1_idle_grp_ready", 64'(grp_ready_o), 64'd1);
      // sparse mask: only slot 1
      grp(2'b10, 3'd0, 3'd0, 64'h1234, 64'hBAD, 64'h0, 64'h0);
      tick();
      clr();
      chk("t2_valid", 64'(valid_o), 64'd1);
      chk("t2_iaddr", iaddr_o, 64'h1234);
      chk("t2_last", 64'(last_o), 64'd1);
      tick();
      chk("t2_idle", 64'(valid_o), 64'd0);
      // stall 5 cycles during a two-block group
      ready_i = 1'b0;
      grp(2'b11, 3'd0, 3'd0, 64'h200, 64'h100, 64'h0, 64'h0);
      tick();
      clr();
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t3_stall_valid", 64'(valid_o), 64'd1);
         chk("t3_stall_iaddr", iaddr_o, 64'h100);
         chk("t3_stall_last", 64'(last_o), 64'd0);
      end
      ready_i = 1'b1;
      tick();
      chk("t3_resume_iaddr", iaddr_o, 64'h200);
      chk("t3_resume_last", 64'(last_o), 64'd1);
      tick();
      chk("t3_idle", 64'(valid_o), 64'd0);
      // exception block carries cause/tval, following plain block does not
      grp(2'b11, 3'd0, 3'd1, 64'h20, 64'h10, 64'h2, 64'hDEAD);
      tick();
      clr();
      chk("t4_exc_itype", 64'(itype_o), 64'd1);
      chk("t4_exc_cause", cause_o, 64'h2);
      chk("t4_exc_tval", tval_o, 64'hDEAD);
      tick();
      chk("t4_plain_itype", 64'(itype_o), 64'd0);
      chk("t4_plain_cause", cause_o, 64'd0);
      chk("t4_plain_tval", tval_o, 64'd0);
      tick();
      // drops while busy, then saturation
      ready_i = 1'b0;
      grp(2'b11, 3'd0, 3'd0, 64'h2, 64'h1, 64'h0, 64'h0);
      tick();
      grp(2'b01, 3'd0, 3'd0, 64'h0, 64'h99, 64'h0, 64'h0);
      #1;
      chk("t5_busy_grp_ready", 64'(grp_ready_o), 64'd0);
      chk("t5_drop_pulse", 64'(drop_o), 64'd1);
      tick();
      clr();
      #1;
      chk("t5_drop_cleared", 64'(drop_o), 64'd0);
      chk("t5_drop_cnt1", 64'(drop_cnt_o), 64'd1);
      chk("t5_inflight_iaddr", iaddr_o, 64'h1);
      grp(2'b01, 3'd0, 3'd0, 64'h0, 64'h99, 64'h0, 64'h0);
      for (int i = 0; i < 299; i++) tick();
      clr();
      #1;
      chk("t5_drop_cnt_sat", 64'(drop_cnt_o), 64'd255);
      chk("t5_inflight_valid", 64'(valid_o), 64'd1);
      chk("t5_inflight_iaddr2", iaddr_o, 64'h1);
      // group on the last handshake: captured without bubble
      ready_i = 1'b1;
      tick();
      chk("t6_last_iaddr", iaddr_o, 64'h2);
      grp(2'b01, 3'd0, 3'd0, 64'h0, 64'h77, 64'h0, 64'h0);
      #1;
      chk("t6_grp_ready", 64'(grp_ready_o), 64'd1);
      chk("t6_no_drop", 64'(drop_o), 64'd0);
      tick();
      clr();
      chk("t6_next_valid", 64'(valid_o), 64'd1);
      chk("t6_next_iaddr", iaddr_o, 64'h77);
      chk("t6_next_last", 64'(last_o), 64'd1);
      chk("t6_cnt_held", 64'(drop_cnt_o), 64'd255);
      tick();
      chk("t6_idle", 64'(valid_o), 64'd0);
      // reset mid-group
      ready_i = 1'b0;
      grp(2'b11, 3'd0, 3'd0, 64'h4, 64'h3, 64'h0, 64'h0);
      tick();
      clr();
      chk("t7_busy_valid", 64'(valid_o), 64'd1);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      #1;
      chk("t7_rst_valid", 64'(valid_o), 64'd0);
      chk("t7_rst_grp_ready", 64'(grp_ready_o), 64'd1);
      chk("t7_rst_drop_cnt", 64'(drop_cnt_o), 64'd0);
      chk("t7_rst_iaddr", iaddr_o, 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
